// File: rtl/nco_freq_meas.sv
// Gated rising-edge counter: reports sig_in frequency as an NCO phase increment.
// Optional build macro NCO_FREQ_MEAS_SYNC_EN adds a 2-flop input synchronizer.
module nco_freq_meas #(
  parameter  int GATE_LOG2 = 20,
  parameter  int PHASE_W   = 64,
  localparam int CNT_W     = GATE_LOG2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sig_in,
  input  logic               start,
  input  logic               continuous,
  output logic               meas_valid,
  input  logic               meas_ready,
  output logic [PHASE_W-1:0] phase_inc_meas,
  output logic [CNT_W-1:0]   edge_count,
  output logic               busy,
  output logic               overrun
);

  typedef enum logic [1:0] {IDLE, GATE, HOLD} state_t;

  localparam logic [GATE_LOG2-1:0] GATE_ONE = GATE_LOG2'(1);

  state_t               state_reg, state_next;
  logic                 sig_s, sig_d_reg, edge_det;
  logic [GATE_LOG2-1:0] gate_cnt_reg;
  logic [CNT_W-1:0]     edge_cnt_reg, res_cnt_reg;
  logic                 load_reg, cont_reg, gate_last;
  logic                 meas_valid_reg, overrun_reg;
  logic [CNT_W-1:0]     edge_count_reg;
  logic [PHASE_W-1:0]   phase_reg;

`ifdef NCO_FREQ_MEAS_SYNC_EN
  logic [1:0] sync_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= 2'b00;
    else        sync_reg <= {sync_reg[0], sig_in};
  end
  assign sig_s = sync_reg[1];
`else
  assign sig_s = sig_in;
`endif

  assign edge_det  = sig_s & ~sig_d_reg;
  assign gate_last = (state_reg == GATE) && (&gate_cnt_reg);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start | continuous) state_next = GATE;
      GATE: if (gate_last) state_next = (cont_reg & continuous) ? GATE : HOLD;
      HOLD: if (meas_valid_reg & meas_ready & ~load_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_reg == GATE);
  end

  // Gate/edge counters; the final count is staged for one cycle so that in
  // back-to-back gates the counter can restart while the result is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_d_reg    <= 1'b0;
      gate_cnt_reg <= '0;
      edge_cnt_reg <= '0;
      res_cnt_reg  <= '0;
      load_reg     <= 1'b0;
      cont_reg     <= 1'b0;
    end else begin
      sig_d_reg <= sig_s;
      load_reg  <= gate_last;
      if (state_reg == IDLE) begin
        gate_cnt_reg <= '0;
        edge_cnt_reg <= '0;
        cont_reg     <= continuous;
      end else if (state_reg == GATE) begin
        gate_cnt_reg <= gate_cnt_reg + GATE_ONE;
        if (gate_last) begin
          res_cnt_reg  <= edge_cnt_reg + CNT_W'(edge_det);
          edge_cnt_reg <= '0;
        end else begin
          edge_cnt_reg <= edge_cnt_reg + CNT_W'(edge_det);
        end
      end
    end
  end

  // Result register with valid/ready handshake; a reload always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
      edge_count_reg <= '0;
      phase_reg      <= '0;
    end else if (load_reg) begin
      edge_count_reg <= res_cnt_reg;
      phase_reg      <= {res_cnt_reg, {(PHASE_W-GATE_LOG2){1'b0}}};
      meas_valid_reg <= 1'b1;
      if (meas_valid_reg & ~meas_ready) overrun_reg <= 1'b1;
    end else if (meas_valid_reg & meas_ready) begin
      meas_valid_reg <= 1'b0;
    end
  end

  assign meas_valid     = meas_valid_reg;
  assign overrun        = overrun_reg;
  assign edge_count     = edge_count_reg;
  assign phase_inc_meas = phase_reg;

endmodule

// File: tb/tb_nco_freq_meas.sv
// Self-checking bench for nco_freq_meas (GATE_LOG2=8): table vectors, random
// stimulus against an edge-history reference model, and multi-cycle corner cases.
module tb_nco_freq_meas;
  localparam int G  = 8;
  localparam int PW = 64;
  localparam int N  = 1 << G;
  localparam int SH = PW - G;
`ifdef NCO_FREQ_MEAS_SYNC_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sig_in = 1'b0;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic          meas_ready = 1'b0;
  logic          meas_valid, busy, overrun;
  logic [PW-1:0] phase_inc_meas;
  logic [G-1:0]  edge_count;

  nco_freq_meas #(.GATE_LOG2(G), .PHASE_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start),
    .continuous(continuous), .meas_valid(meas_valid), .meas_ready(meas_ready),
    .phase_inc_meas(phase_inc_meas), .edge_count(edge_count),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // History of sig_in as seen at each rising edge, indexed by edge number.
  bit hist [0:32767];
  int cyc = 0;
  always @(posedge clk) begin
    if (cyc < 32768) hist[cyc] = sig_in;
    cyc = cyc + 1;
  end

  // Stimulus generator: 0 constant, 1 square wave, 2 random bits, 3 NCO MSB.
  int          gen_mode = 0;
  int          half = 1;
  int          gcnt = 0;
  bit          gen_level = 1'b0;
  logic [63:0] acc = '0;
  logic [63:0] inc = '0;
  always @(negedge clk) begin
    gcnt = gcnt + 1;
    case (gen_mode)
      0: sig_in = gen_level;
      1: sig_in = ((gcnt / half) % 2) != 0;
      2: sig_in = ($urandom % 2) != 0;
      default: begin
        acc = acc + inc;
        sig_in = acc[63];
      end
    endcase
  end

  // Rising edges of the (possibly synchronized) input over the gate that was
  // started by the edge with index t: gate edges are t+1 .. t+N.
  function automatic int model_count(input int t);
    int c = 0;
    for (int k = t + 1; k <= t + N; k++)
      if (hist[k-DLY] && !hist[k-DLY-1]) c++;
    return c;
  endfunction

  function automatic logic [63:0] model_phase(input int c);
    logic [63:0] v;
    v = 64'(c);
    return v << SH;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end else
      $display("ok   %s: 0x%0h", nm, act);
  endtask

  task automatic check_range(input string nm, input longint act, input longint lo, input longint hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end else
      $display("ok   %s: %0d in %0d..%0d", nm, act, lo, hi);
  endtask

  task automatic wait_valid(input string nm, output int e);
    int b = 0;
    e = -1;
    do begin
      @(negedge clk);
      b++;
    end while (meas_valid !== 1'b1 && b < 2000);
    if (meas_valid === 1'b1) e = cyc - 1;
    else begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: meas_valid timeout, got 0, expected 1", nm);
    end
  endtask

  task automatic single_meas(input string nm, output int t, output int e);
    @(negedge clk);
    start = 1'b1;
    t = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    start = 1'b1;            // must be ignored while busy
    @(negedge clk);
    start = 1'b0;
    wait_valid(nm, e);
  endtask

  task automatic ack(input string nm);
    @(negedge clk);
    meas_ready = 1'b1;
    @(negedge clk);
    meas_ready = 1'b0;
    check({nm, " valid drop"}, 64'(meas_valid), 64'd0);
    check({nm, " idle busy"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    int half;
    bit level;
    int exp_nom;
    int tol;
  } vec_t;
  vec_t vecs [5];

  initial begin
    int t, e, m;
    logic [63:0] diff, sv_ph;
    logic [G-1:0] sv_ec;
    bit stable;

    vecs[0] = '{half: 8, level: 1'b0, exp_nom: 16,  tol: 1};
    vecs[1] = '{half: 1, level: 1'b0, exp_nom: 128, tol: 0};
    vecs[2] = '{half: 0, level: 1'b0, exp_nom: 0,   tol: 0};
    vecs[3] = '{half: 0, level: 1'b1, exp_nom: 0,   tol: 0};
    vecs[4] = '{half: 4, level: 1'b0, exp_nom: 32,  tol: 1};

    @(negedge clk);
    check("reset valid", 64'(meas_valid), 0);
    check("reset busy", 64'(busy), 0);
    check("reset overrun", 64'(overrun), 0);
    check("reset count", 64'(edge_count), 0);
    check("reset phase", phase_inc_meas, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    foreach (vecs[i]) begin
      gen_mode  = (vecs[i].half > 0) ? 1 : 0;
      half      = (vecs[i].half > 0) ? vecs[i].half : 1;
      gen_level = vecs[i].level;
      gcnt      = $urandom % 64;
      repeat (4) @(negedge clk);
      single_meas($sformatf("vec%0d", i), t, e);
      m = model_count(t);
      check($sformatf("vec%0d count", i), 64'(edge_count), 64'(m));
      check_range($sformatf("vec%0d nominal", i), longint'(edge_count),
                  vecs[i].exp_nom - vecs[i].tol, vecs[i].exp_nom + vecs[i].tol);
      check($sformatf("vec%0d phase", i), phase_inc_meas, model_phase(m));
      check($sformatf("vec%0d latency", i), 64'(e - t), 64'(N + 1));
      ack($sformatf("vec%0d", i));
    end

    // NCO loopback: increment 2^58 -> 4 edges per 256-cycle gate.
    inc = 64'h0400_0000_0000_0000;
    acc = {$urandom, $urandom};
    gen_mode = 3;
    repeat (4) @(negedge clk);
    single_meas("loopback", t, e);
    m = model_count(t);
    check("loopback count", 64'(edge_count), 64'(m));
    diff = (phase_inc_meas > inc) ? phase_inc_meas - inc : inc - phase_inc_meas;
    check_range("loopback phase err/2^56", longint'(diff >> 56), 0, 1);
    ack("loopback");

    for (int r = 0; r < 6; r++) begin
      gen_mode = (r % 2 == 0) ? 2 : 1;
      half     = 1 + ($urandom % 40);
      gcnt     = $urandom % 97;
      repeat (4) @(negedge clk);
      single_meas($sformatf("rand%0d", r), t, e);
      m = model_count(t);
      check($sformatf("rand%0d count", r), 64'(edge_count), 64'(m));
      check($sformatf("rand%0d phase", r), phase_inc_meas, model_phase(m));
      ack($sformatf("rand%0d", r));
    end

    // Backpressure in single mode.
    gen_mode = 1;
    half = 8;
    single_meas("bp", t, e);
    sv_ec = edge_count;
    sv_ph = phase_inc_meas;
    stable = 1'b1;
    repeat (500) begin
      @(negedge clk);
      if (meas_valid !== 1'b1 || busy !== 1'b0 || edge_count !== sv_ec || phase_inc_meas !== sv_ph)
        stable = 1'b0;
    end
    check("bp hold stable", 64'(stable), 64'd1);
    check("bp count", 64'(edge_count), 64'(model_count(t)));
    ack("bp");

    // Continuous mode without acceptance: second result overwrites the first.
    gen_mode = 2;
    @(negedge clk);
    continuous = 1'b1;
    t = cyc;
    wait_valid("cont0 first", e);
    check("cont0 first latency", 64'(e - t), 64'(N + 1));
    check("cont0 first count", 64'(edge_count), 64'(model_count(t)));
    check("cont0 first overrun", 64'(overrun), 64'd0);
    while (cyc - 1 < t + 2 * N + 1) @(negedge clk);
    check("cont0 second count", 64'(edge_count), 64'(model_count(t + N)));
    check("cont0 second valid", 64'(meas_valid), 64'd1);
    check("cont0 second overrun", 64'(overrun), 64'd1);

    // Asynchronous reset between clock edges in the middle of a gate.
    repeat (50) @(negedge clk);
    #2;
    rst_n = 1'b0;
    continuous = 1'b0;
    #1;
    check("areset valid", 64'(meas_valid), 0);
    check("areset busy", 64'(busy), 0);
    check("areset overrun", 64'(overrun), 0);
    check("areset count", 64'(edge_count), 0);
    check("areset phase", phase_inc_meas, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    gen_mode = 1;
    half = 5;
    single_meas("post-reset", t, e);
    m = model_count(t);
    check("post-reset count", 64'(edge_count), 64'(m));
    check("post-reset latency", 64'(e - t), 64'(N + 1));
    ack("post-reset");

    // Continuous mode with the consumer always ready.
    meas_ready = 1'b1;
    gen_mode = 2;
    @(negedge clk);
    continuous = 1'b1;
    t = cyc;
    for (int k = 0; k < 3; k++) begin
      wait_valid($sformatf("cont1 r%0d", k), e);
      check($sformatf("cont1 r%0d time", k), 64'(e - t), 64'(N + 1 + k * N));
      check($sformatf("cont1 r%0d count", k), 64'(edge_count), 64'(model_count(t + k * N)));
      check($sformatf("cont1 r%0d overrun", k), 64'(overrun), 64'd0);
    end
    continuous = 1'b0;
    wait_valid("cont1 last", e);
    check("cont1 last time", 64'(e - t), 64'(4 * N + 1));
    check("cont1 last count", 64'(edge_count), 64'(model_count(t + 3 * N)));
    @(negedge clk);
    check("cont1 exit valid", 64'(meas_valid), 64'd0);
    check("cont1 exit busy", 64'(busy), 64'd0);
    meas_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
